// File: rtl/conv_pkg.sv
// Shared definitions for the 5x5 convolution datapath blocks.
//   KSIZE     : kernel edge length
//   KAREA     : elements per window/kernel
//   BIAS_BITS : width of the signed per-filter bias
//   sched_state_t : filter scheduler FSM states
package conv_pkg;

  localparam int unsigned KSIZE     = 5;
  localparam int unsigned KAREA     = KSIZE * KSIZE;
  localparam int unsigned BIAS_BITS = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } sched_state_t;

endpackage

// File: rtl/conv5x5_filter_scheduler.sv
// conv5x5_filter_scheduler
//   Time-multiplexes one shared 5x5 signed convolution engine across
//   NUM_FILTERS output channels. A window is latched once, then for each
//   channel the kernel/bias is read from weight memory, issued to the engine,
//   and the engine result is emitted on a valid/ready stream.
//
// Ports
//   clk, rst_n                    : clock (rising edge), async active-low reset
//   win_valid/win_ready/win_data  : input window stream (p00 in LSBs, row-major)
//   wt_rd_en/wt_addr              : weight memory read (data valid 1 cycle later)
//   wt_kern/wt_bias               : kernel and bias from weight memory
//   eng_valid_in/eng_win/eng_kern/eng_bias : engine issue
//   eng_valid_out/eng_y           : engine result (1-cycle latency)
//   out_valid/out_ready/out_data/out_ch/out_last : per-channel result stream
//   busy                          : high whenever the FSM is not idle
//
// Configuration
//   CONV_SCHED_RELU_EN : when defined, negative engine results are stored as 0.
module conv5x5_filter_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SUM_BITS    = 24,
  parameter int unsigned NUM_FILTERS = 8,
  parameter int unsigned CH_BITS     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         win_valid,
  output logic                         win_ready,
  input  logic [KAREA*DATA_BITS-1:0]   win_data,
  output logic                         wt_rd_en,
  output logic [CH_BITS-1:0]           wt_addr,
  input  logic [KAREA*DATA_BITS-1:0]   wt_kern,
  input  logic [BIAS_BITS-1:0]         wt_bias,
  output logic                         eng_valid_in,
  output logic [KAREA*DATA_BITS-1:0]   eng_win,
  output logic [KAREA*DATA_BITS-1:0]   eng_kern,
  output logic [BIAS_BITS-1:0]         eng_bias,
  input  logic                         eng_valid_out,
  input  logic [SUM_BITS-1:0]          eng_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_BITS-1:0]          out_data,
  output logic [CH_BITS-1:0]           out_ch,
  output logic                         out_last,
  output logic                         busy
);

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_FILTERS - 1);

  sched_state_t                 r_state;
  logic [CH_BITS-1:0]           r_ch;
  logic [KAREA*DATA_BITS-1:0]   r_win;
  logic                         r_out_valid;
  logic [SUM_BITS-1:0]          r_out_data;
  logic [CH_BITS-1:0]           r_out_ch;
  logic                         r_out_last;
  logic                         r_wt_rd_en;
  logic                         r_eng_valid_in;
  logic [SUM_BITS-1:0]          w_capture;

`ifdef CONV_SCHED_RELU_EN
  assign w_capture = eng_y[SUM_BITS-1] ? '0 : eng_y;
`else
  assign w_capture = eng_y;
`endif

  // Strobes are registered: they are raised on the edge that enters
  // FETCH/ISSUE and dropped on the following edge, so each lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_ch           <= '0;
      r_win          <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_ch       <= '0;
      r_out_last     <= 1'b0;
      r_wt_rd_en     <= 1'b0;
      r_eng_valid_in <= 1'b0;
    end else begin
      r_wt_rd_en     <= 1'b0;
      r_eng_valid_in <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (win_valid) begin
            r_win      <= win_data;
            r_ch       <= '0;
            r_wt_rd_en <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_eng_valid_in <= 1'b1;
          r_state        <= S_ISSUE;
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_valid_out) begin
            r_out_data  <= w_capture;
            r_out_ch    <= r_ch;
            r_out_last  <= (r_ch == LAST_CH);
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_state <= S_IDLE;
            end else begin
              r_ch       <= r_ch + 1'b1;
              r_wt_rd_en <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign win_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign wt_rd_en     = r_wt_rd_en;
  assign wt_addr      = r_ch;
  assign eng_valid_in = r_eng_valid_in;
  assign eng_win      = r_win;
  assign eng_kern     = wt_kern;
  assign eng_bias     = wt_bias;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_ch       = r_out_ch;
  assign out_last     = r_out_last;

endmodule

// File: tb/tb_conv5x5_filter_scheduler.sv
// Directed testbench for conv5x5_filter_scheduler with NUM_FILTERS=4.
// Provides a registered weight memory and a 1-cycle-latency engine model.
module tb_conv5x5_filter_scheduler;

  localparam int unsigned DB = 8;
  localparam int unsigned SB = 24;
  localparam int unsigned NF = 4;
  localparam int unsigned CB = 2;
  localparam int unsigned VW = 25 * DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          win_valid;
  logic          win_ready;
  logic [VW-1:0] win_data;
  logic          wt_rd_en;
  logic [CB-1:0] wt_addr;
  logic [VW-1:0] wt_kern;
  logic [23:0]   wt_bias;
  logic          eng_valid_in;
  logic [VW-1:0] eng_win;
  logic [VW-1:0] eng_kern;
  logic [23:0]   eng_bias;
  logic          eng_valid_out;
  logic [SB-1:0] eng_y;
  logic          out_valid;
  logic          out_ready;
  logic [SB-1:0] out_data;
  logic [CB-1:0] out_ch;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [VW-1:0] mem_kern [NF];
  logic [23:0]   mem_bias [NF];

  conv5x5_filter_scheduler #(
    .DATA_BITS  (DB),
    .SUM_BITS   (SB),
    .NUM_FILTERS(NF),
    .CH_BITS    (CB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .win_data     (win_data),
    .wt_rd_en     (wt_rd_en),
    .wt_addr      (wt_addr),
    .wt_kern      (wt_kern),
    .wt_bias      (wt_bias),
    .eng_valid_in (eng_valid_in),
    .eng_win      (eng_win),
    .eng_kern     (eng_kern),
    .eng_bias     (eng_bias),
    .eng_valid_out(eng_valid_out),
    .eng_y        (eng_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] fill(input logic [7:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < 25; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [SB-1:0] engine_dot(input logic [VW-1:0] w, input logic [VW-1:0] k,
                                               input logic [23:0] b);
    int acc;
    acc = $signed(b);
    for (int i = 0; i < 25; i++) acc += $signed(w[i*8 +: 8]) * $signed(k[i*8 +: 8]);
    return acc[SB-1:0];
  endfunction

  // Weight memory: registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wt_rd_en) begin
      wt_kern <= mem_kern[wt_addr];
      wt_bias <= mem_bias[wt_addr];
    end
  end

  // Engine: 1-cycle latency, no stall.
  always @(posedge clk) begin
    eng_valid_out <= eng_valid_in;
    if (eng_valid_in) eng_y <= engine_dot(eng_win, eng_kern, eng_bias);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output bit ok);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    ok = out_valid;
  endtask

  task automatic load_weights_ramp;
    for (int c = 0; c < int'(NF); c++) begin
      mem_kern[c] = fill(8'(c + 1));
      mem_bias[c] = '0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; win_valid = 1'b1; win_data = fill(8'd1); out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (win_ready !== 1'b1) begin errors++; $display("FAIL reset_win_ready got %b exp 1", win_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (wt_rd_en !== 1'b0 || eng_valid_in !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got wt_rd_en=%b eng_valid_in=%b exp 0/0", wt_rd_en, eng_valid_in); end
    checks++; if (out_data !== '0 || out_ch !== '0 || out_last !== 1'b0 || eng_win !== '0) begin
      errors++; $display("FAIL reset_regs got data=%h ch=%0d last=%b win_nz=%b exp zeros", out_data, out_ch, out_last, |eng_win); end
    win_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (wt_rd_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_no_fetch cyc%0d got wt_rd_en=%b busy=%b exp 0/0", i, wt_rd_en, busy); end
    end
  endtask

  task automatic test_four_channels;
    logic [SB-1:0] exp_d [4] = '{24'd25, 24'd50, 24'd75, 24'd100};
    bit ok;
    load_weights_ramp();
    win_data = fill(8'd1); win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    checks++; if (wt_rd_en !== 1'b1 || wt_addr !== 2'd0 || busy !== 1'b1 || win_ready !== 1'b0) begin
      errors++; $display("FAIL fetch_ch0 got rd=%b addr=%0d busy=%b rdy=%b exp 1/0/1/0", wt_rd_en, wt_addr, busy, win_ready); end
    tick();
    checks++; if (eng_valid_in !== 1'b1 || wt_rd_en !== 1'b0 || eng_kern !== fill(8'd1) || eng_win !== fill(8'd1)) begin
      errors++; $display("FAIL issue_ch0 got ev=%b rd=%b kern_ok=%b win_ok=%b exp 1/0/1/1",
                         eng_valid_in, wt_rd_en, eng_kern === fill(8'd1), eng_win === fill(8'd1)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_3edges got %b exp 1", out_valid); end
    for (int c = 0; c < 4; c++) begin
      wait_out_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_timeout ch%0d got no out_valid exp out_valid", c); end
      checks++; if (out_data !== exp_d[c] || out_ch !== 2'(c) || out_last !== (c == 3)) begin
        errors++; $display("FAIL basic_ch%0d got data=%0d ch=%0d last=%b exp %0d/%0d/%b",
                           c, out_data, out_ch, out_last, exp_d[c], c, c == 3); end
      tick();
    end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done got busy=%b ov=%b exp 0/0", busy, out_valid); end
  endtask

  task automatic test_backpressure;
    logic [SB-1:0] exp_d [4] = '{24'd50, 24'd100, 24'd150, 24'd200};
    bit ok;
    win_data = fill(8'd2); win_valid = 1'b1; out_ready = 1'b1;
    tick();
    win_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wait_out_valid(ok);
      checks++; if (!ok || out_data !== exp_d[c] || out_ch !== 2'(c)) begin
        errors++; $display("FAIL bp_ch%0d got ok=%b data=%0d ch=%0d exp 1/%0d/%0d", c, ok, out_data, out_ch, exp_d[c], c); end
      if (c == 1) begin
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          tick();
          checks++; if (out_valid !== 1'b1 || out_data !== 24'd100 || out_ch !== 2'd1 ||
                        wt_rd_en !== 1'b0 || eng_valid_in !== 1'b0) begin
            errors++; $display("FAIL bp_hold cyc%0d got ov=%b data=%0d ch=%0d rd=%b ev=%b exp 1/100/1/0/0",
                               i, out_valid, out_data, out_ch, wt_rd_en, eng_valid_in); end
        end
        out_ready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [SB-1:0] exp_a [4] = '{24'd25, 24'd50, 24'd75, 24'd100};
    logic [SB-1:0] exp_b [4] = '{24'd75, 24'd150, 24'd225, 24'd300};
    int acc_cyc;
    int n;
    bit ok;
    win_data = fill(8'd1); win_valid = 1'b1;
    tick();
    acc_cyc = cyc;
    win_data = fill(8'd3);
    for (int c = 0; c < 4; c++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        checks++; if (win_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b exp 0", win_ready); end
        tick(); n++;
      end
      checks++; if (!out_valid || out_data !== exp_a[c] || eng_win !== fill(8'd1)) begin
        errors++; $display("FAIL b2b_a_ch%0d got ov=%b data=%0d win_held=%b exp 1/%0d/1",
                           c, out_valid, out_data, eng_win === fill(8'd1), exp_a[c]); end
      tick();
    end
    checks++; if (win_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got rdy=%b busy=%b exp 1/0", win_ready, busy); end
    tick();
    win_valid = 1'b0;
    checks++; if (busy !== 1'b1 || wt_rd_en !== 1'b1 || wt_addr !== 2'd0) begin
      errors++; $display("FAIL b2b_accept got busy=%b rd=%b addr=%0d exp 1/1/0", busy, wt_rd_en, wt_addr); end
    checks++; if (cyc - acc_cyc !== 17) begin
      errors++; $display("FAIL b2b_interval got %0d exp 17", cyc - acc_cyc); end
    for (int c = 0; c < 4; c++) begin
      wait_out_valid(ok);
      checks++; if (!ok || out_data !== exp_b[c] || out_ch !== 2'(c) || out_last !== (c == 3)) begin
        errors++; $display("FAIL b2b_b_ch%0d got ok=%b data=%0d ch=%0d last=%b exp 1/%0d/%0d/%b",
                           c, ok, out_data, out_ch, out_last, exp_b[c], c, c == 3); end
      tick();
    end
  endtask

  task automatic test_negative_result;
    logic [SB-1:0] exp_y;
    bit ok;
`ifdef CONV_SCHED_RELU_EN
    exp_y = '0;
`else
    exp_y = 24'hFFFFF9;
`endif
    for (int c = 0; c < int'(NF); c++) begin
      mem_kern[c] = fill(8'hFF);
      mem_bias[c] = 24'd18;
    end
    win_data = fill(8'd1); win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wait_out_valid(ok);
      checks++; if (!ok || out_data !== exp_y || out_ch !== 2'(c)) begin
        errors++; $display("FAIL neg_ch%0d got ok=%b data=%h ch=%0d exp 1/%h/%0d", c, ok, out_data, out_ch, exp_y, c); end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    load_weights_ramp();
    win_data = fill(8'd1); win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      wait_out_valid(ok);
      tick();
    end
    n = 0;
    while (!(wt_rd_en && wt_addr == 2'd2) && n < 20) begin tick(); n++; end
    checks++; if (!(wt_rd_en && wt_addr == 2'd2)) begin
      errors++; $display("FAIL mid_fetch2 got rd=%b addr=%0d exp 1/2", wt_rd_en, wt_addr); end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || wt_rd_en !== 1'b0 || eng_valid_in !== 1'b0 || busy !== 1'b0 ||
                  win_ready !== 1'b1 || out_data !== '0 || out_ch !== '0 || out_last !== 1'b0 || eng_win !== '0) begin
      errors++; $display("FAIL mid_reset got ov=%b rd=%b ev=%b busy=%b rdy=%b data=%0d ch=%0d exp 0/0/0/0/1/0/0",
                         out_valid, wt_rd_en, eng_valid_in, busy, win_ready, out_data, out_ch); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_after_release cyc%0d got ov=%b busy=%b exp 0/0", i, out_valid, busy); end
    end
    win_data = fill(8'd2); win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wait_out_valid(ok);
      checks++; if (!ok || out_ch !== 2'(c) || out_data !== 24'(50 * (c + 1))) begin
        errors++; $display("FAIL mid_restart_ch%0d got ok=%b ch=%0d data=%0d exp 1/%0d/%0d", c, ok, out_ch, out_data, c, 50 * (c + 1)); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; win_valid = 1'b0; win_data = '0; out_ready = 1'b1;
    load_weights_ramp();
    test_reset();
    test_four_channels();
    test_backpressure();
    test_back_to_back();
    test_negative_result();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
